// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: 8N1 UART receiver with per-byte strobe and 32-bit little-endian word assembly.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions (all strobes one tick later).
module uart_rx_monitor #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        rxd,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        frame_err,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        busy
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int SW  = $clog2(OVERSAMPLE);
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    localparam logic [SW-1:0] START_AT = SW'(OVERSAMPLE / 2 - 1 + MAJ);
    localparam logic [SW-1:0] BIT_AT   = SW'((OVERSAMPLE - 1 + MAJ) % OVERSAMPLE);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;

    logic          s1, rxs, rxs_d, armed;
    logic [1:0]    vld;
    logic [DW-1:0] cnt;
    logic          tick;
    logic [SW-1:0] sc;
    logic [2:0]    idx;
    logic [7:0]    shreg;
    logic [1:0]    bc;
    logic [23:0]   shadow;
    logic          smp, start_edge, at_start, at_bit, good, bad;

    assign tick = cnt == DW'(DIV - 1);

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;
    assign smp = (hist[1] & hist[0]) | (rxs & (hist[1] | hist[0]));
    always_ff @(posedge CLK100MHZ) begin
        if (!reset)
            hist <= 2'b11;
        else if (tick)
            hist <= {hist[0], rxs};
    end
`else
    assign smp = rxs;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start_edge ? START : IDLE;
            START:   state_n = at_start ? (smp ? IDLE : DATA) : START;
            DATA:    state_n = at_bit && idx == 3'd7 ? STOP : DATA;
            STOP:    state_n = at_bit ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end

    // A start edge only counts once the line has been seen high after reset.
    always_comb begin
        start_edge = state == IDLE && armed && rxs_d && !rxs;
        at_start   = state == START && tick && sc == START_AT;
        at_bit     = (state == DATA || state == STOP) && tick && sc == BIT_AT;
        good       = state == STOP && at_bit && smp;
        bad        = state == STOP && at_bit && !smp;
        busy       = state != IDLE;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!reset) begin
            s1         <= 1'b1;
            rxs        <= 1'b1;
            rxs_d      <= 1'b1;
            vld        <= '0;
            armed      <= 1'b0;
            cnt        <= '0;
            sc         <= '0;
            idx        <= '0;
            shreg      <= '0;
            bc         <= '0;
            shadow     <= '0;
            rx_byte    <= '0;
            word       <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            word_valid <= 1'b0;
        end else begin
            s1         <= rxd;
            rxs        <= s1;
            rxs_d      <= rxs;
            vld        <= {vld[0], 1'b1};
            armed      <= armed | (vld[1] & rxs);
            cnt        <= start_edge || tick ? '0 : cnt + 1'b1;
            sc         <= start_edge ? '0 : at_start ? SW'(MAJ) : tick ? sc + 1'b1 : sc;
            rx_valid   <= good;
            frame_err  <= bad;
            word_valid <= good && bc == 2'd3;
            if (at_start)
                idx <= '0;
            else if (state == DATA && at_bit) begin
                shreg <= {smp, shreg[7:1]};
                idx   <= idx + 1'b1;
            end
            // Shadow shifts right so lanes 0..2 sit in [23:0] when the fourth byte arrives.
            if (good) begin
                rx_byte <= shreg;
                shadow  <= {shreg, shadow[23:8]};
                bc      <= bc + 1'b1;
                if (bc == 2'd3)
                    word <= {shreg, shadow};
            end else if (bad)
                bc <= '0;
        end
    end
endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb_uart_rx_monitor: scenario tasks plus a randomized run against a queue-based frame model.
module tb_uart_rx_monitor;
    localparam int OS     = 16;
    localparam int DIV    = 8;
    localparam int BAUD   = 115200;
    localparam int CLK_HZ = BAUD * OS * DIV;
    localparam int BIT    = OS * DIV;
    localparam int HALF   = BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif

    logic        clk = 1'b0, reset = 1'b0, rxd = 1'b1;
    logic [7:0]  rx_byte;
    logic        rx_valid, frame_err, word_valid, busy;
    logic [31:0] word;

    int          vectors = 0, miscompares = 0, n_ferr = 0;
    logic [7:0]  got_b[$];
    logic [31:0] got_w[$];

    uart_rx_monitor #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
        .CLK100MHZ(clk), .reset(reset), .rxd(rxd), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .frame_err(frame_err), .word(word), .word_valid(word_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) got_b.push_back(rx_byte);
        if (frame_err) n_ferr++;
        if (word_valid) got_w.push_back(word);
        if (rx_valid || frame_err || word_valid) begin
            vectors++;
            if ((rx_valid && frame_err) || (word_valid && !rx_valid) || busy) begin
                $display("FAIL strobes: rx_valid=%b frame_err=%b word_valid=%b busy=%b, required exclusive strobes, word_valid only with rx_valid, busy low",
                         rx_valid, frame_err, word_valid, busy);
                miscompares++;
            end
        end
    end

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int len);
        hold(1'b0, len);
        for (int i = 0; i < 8; i++) hold(b[i], len);
        hold(stop, len);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        got_b.delete();
        got_w.delete();
        n_ferr = 0;
    endtask

    task automatic test_reset();
        rxd = 1'b0;
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        vectors++;
        if ({rx_byte, word, rx_valid, frame_err, word_valid, busy} !== 44'h0) begin
            $display("FAIL reset_state: rx_byte=%h word=%h strobes=%b%b%b busy=%b, required all zero",
                     rx_byte, word, rx_valid, frame_err, word_valid, busy);
            miscompares++;
        end
        reset = 1'b1;
        got_b.delete();
        got_w.delete();
        n_ferr = 0;
        hold(1'b0, 2 * BIT);
        vectors++;
        if (busy !== 1'b0 || got_b.size() != 0 || n_ferr != 0) begin
            $display("FAIL low_at_release: busy=%b bytes=%0d ferr=%0d, required 0 0 0", busy, got_b.size(), n_ferr);
            miscompares++;
        end
        hold(1'b1, BIT);
    endtask

    task automatic test_single_byte();
        logic [7:0] b = 8'hA5;
        do_reset();
        hold(1'b1, 20);
        hold(1'b0, BIT);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL busy_in_frame: got %b, required 1", busy);
            miscompares++;
        end
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(1'b1, BIT);
        vectors++;
        if (got_b.size() != 1 || got_b[0] !== 8'hA5 || rx_byte !== 8'hA5) begin
            $display("FAIL single_byte: count=%0d rx_byte=%h, required 1 a5", got_b.size(), rx_byte);
            miscompares++;
        end
        vectors++;
        if (n_ferr != 0 || got_w.size() != 0 || busy !== 1'b0) begin
            $display("FAIL single_side: ferr=%0d words=%0d busy=%b, required 0 0 0", n_ferr, got_w.size(), busy);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        hold(1'b1, 20);
        send_byte(8'h78, 1'b1, BIT);
        send_byte(8'h56, 1'b1, BIT);
        send_byte(8'h34, 1'b1, BIT);
        send_byte(8'h12, 1'b1, BIT);
        hold(1'b1, BIT);
        vectors++;
        if (got_b.size() != 4 || got_b[3] !== 8'h12) begin
            $display("FAIL b2b_bytes: count=%0d, required 4 ending 12", got_b.size());
            miscompares++;
        end
        vectors++;
        if (got_w.size() != 1 || got_w[0] !== 32'h12345678 || word !== 32'h12345678) begin
            $display("FAIL b2b_word: count=%0d word=%h, required 1 12345678", got_w.size(), word);
            miscompares++;
        end
    endtask

    task automatic test_frame_error();
        do_reset();
        hold(1'b1, 20);
        send_byte(8'h11, 1'b1, BIT);
        send_byte(8'h22, 1'b1, BIT);
        send_byte(8'h3C, 1'b0, BIT);
        hold(1'b1, BIT);
        vectors++;
        if (n_ferr != 1 || got_b.size() != 2 || rx_byte !== 8'h22) begin
            $display("FAIL ferr_pulse: ferr=%0d bytes=%0d rx_byte=%h, required 1 2 22", n_ferr, got_b.size(), rx_byte);
            miscompares++;
        end
        send_byte(8'hAA, 1'b1, BIT);
        send_byte(8'hBB, 1'b1, BIT);
        send_byte(8'hCC, 1'b1, BIT);
        send_byte(8'hDD, 1'b1, BIT);
        hold(1'b1, BIT);
        vectors++;
        if (got_w.size() != 1 || got_w[0] !== 32'hDDCCBBAA) begin
            $display("FAIL ferr_word: count=%0d word=%h, required 1 ddccbbaa", got_w.size(), word);
            miscompares++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        hold(1'b1, 20);
        hold(1'b0, HALF / 2);
        vectors++;
        if (busy !== 1'b1) begin
            $display("FAIL glitch_busy: got %b, required 1", busy);
            miscompares++;
        end
        hold(1'b1, HALF + 8 + MAJ * DIV - HALF / 2);
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL glitch_idle: busy=%b, required 0", busy);
            miscompares++;
        end
        hold(1'b1, 10 * BIT);
        vectors++;
        if (got_b.size() != 0 || n_ferr != 0 || got_w.size() != 0) begin
            $display("FAIL glitch_strobes: bytes=%0d ferr=%0d words=%0d, required none", got_b.size(), n_ferr, got_w.size());
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b = 8'h5A;
        do_reset();
        hold(1'b1, 20);
        send_byte(8'h01, 1'b1, BIT);
        send_byte(8'h02, 1'b1, BIT);
        hold(1'b0, BIT);
        for (int i = 0; i < 4; i++) hold(b[i], BIT);
        hold(b[4], HALF / 2);
        do_reset();
        vectors++;
        if (rx_byte !== 8'h00 || busy !== 1'b0) begin
            $display("FAIL midreset_state: rx_byte=%h busy=%b, required 00 0", rx_byte, busy);
            miscompares++;
        end
        hold(1'b1, BIT);
        send_byte(8'hC3, 1'b1, BIT);
        hold(1'b1, 10);
        vectors++;
        if (got_b.size() != 1 || rx_byte !== 8'hC3 || n_ferr != 0) begin
            $display("FAIL midreset_byte: count=%0d rx_byte=%h ferr=%0d, required 1 c3 0", got_b.size(), rx_byte, n_ferr);
            miscompares++;
        end
        send_byte(8'h44, 1'b1, BIT);
        send_byte(8'h55, 1'b1, BIT);
        send_byte(8'h66, 1'b1, BIT);
        hold(1'b1, BIT);
        vectors++;
        if (got_w.size() != 1 || word !== 32'h665544C3) begin
            $display("FAIL midreset_word: count=%0d word=%h, required 1 665544c3", got_w.size(), word);
            miscompares++;
        end
    endtask

    task automatic test_spike();
        logic [7:0] exp_b = MAJ ? 8'h00 : 8'h08;
        do_reset();
        hold(1'b1, 20);
        hold(1'b0, 4 * BIT);
        hold(1'b0, HALF - 1);
        hold(1'b1, 3);
        hold(1'b0, BIT - HALF - 2);
        for (int i = 4; i < 8; i++) hold(1'b0, BIT);
        hold(1'b1, 2 * BIT);
        vectors++;
        if (got_b.size() != 1 || rx_byte !== exp_b) begin
            $display("FAIL spike: count=%0d rx_byte=%h, required 1 %h", got_b.size(), rx_byte, exp_b);
            miscompares++;
        end
    endtask

    task automatic test_random();
        logic [7:0]  eb[$], part[$];
        logic [31:0] ew[$];
        logic [7:0]  b;
        logic        ok;
        int          ef = 0;
        do_reset();
        hold(1'b1, 20);
        for (int n = 0; n < 16; n++) begin
            b  = 8'($urandom);
            ok = $urandom_range(0, 4) != 0;
            send_byte(b, ok, BIT - 2 + int'($urandom_range(0, 4)));
            hold(1'b1, ok ? int'($urandom_range(0, 20)) : 4 + int'($urandom_range(0, 20)));
            if (ok) begin
                eb.push_back(b);
                part.push_back(b);
                if (part.size() == 4) begin
                    ew.push_back({part[3], part[2], part[1], part[0]});
                    part.delete();
                end
            end else begin
                ef++;
                part.delete();
            end
        end
        hold(1'b1, BIT);
        vectors++;
        if (got_b.size() != eb.size() || n_ferr != ef || got_w.size() != ew.size()) begin
            $display("FAIL rand_counts: bytes=%0d ferr=%0d words=%0d, required %0d %0d %0d",
                     got_b.size(), n_ferr, got_w.size(), eb.size(), ef, ew.size());
            miscompares++;
        end
        for (int i = 0; i < eb.size() && i < got_b.size(); i++) begin
            vectors++;
            if (got_b[i] !== eb[i]) begin
                $display("FAIL rand_byte[%0d]: got %h, required %h", i, got_b[i], eb[i]);
                miscompares++;
            end
        end
        for (int i = 0; i < ew.size() && i < got_w.size(); i++) begin
            vectors++;
            if (got_w[i] !== ew[i]) begin
                $display("FAIL rand_word[%0d]: got %h, required %h", i, got_w[i], ew[i]);
                miscompares++;
            end
        end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        test_spike();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
